// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write / core-control outputs of the ROM loader.
interface rom_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [15:0] w_rom_addr_o;
  logic [31:0] w_rom_data_o;
  logic        en_w_rom_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, w_rom_addr_o, w_rom_data_o, en_w_rom_o,
           cpu_hold_o, done_o, err_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, w_rom_addr_o, w_rom_data_o, en_w_rom_o,
           cpu_hold_o, done_o, err_o
  );
endinterface

// File: rtl/rom_loader.sv
// Framed byte-stream ROM loader: sync, 16-bit word count, LSB-first words, XOR checksum.
// Holds the core for the whole frame and writes one 32-bit word per WRITE cycle.
module rom_loader #(
  parameter int unsigned MAX_ROM_ADDR = 255,
  parameter int unsigned TIMEOUT      = 1000
) (
  input logic         clk_i,
  input logic         rst_i,
  rom_loader_if.slave bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [16:0] N_MAX = 17'(MAX_ROM_ADDR + 1);
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t         state;
  logic [15:0]    n_words;
  logic [15:0]    word_idx;
  logic [1:0]     byte_cnt;
  logic [7:0]     len_l;
  logic [7:0]     csum;
  logic [23:0]    word_lo;
  logic [TO_W-1:0] to_cnt;

  logic        xfer;
  logic        counting;
  logic        to_hit;
  logic [15:0] n_new;
  logic [16:0] idx_next;

  assign xfer     = bus.byte_valid_i & bus.byte_ready_o;
  assign counting = ((state == S_LEN) || (state == S_DATA) || (state == S_CSUM)) && !xfer;
  assign to_hit   = counting && (to_cnt == TO_W'(TIMEOUT - 1));
  assign n_new    = {bus.byte_i, len_l};
  assign idx_next = {1'b0, word_idx} + 17'd1;

  // Outputs are updated on each transition so they always reflect the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= S_IDLE;
      bus.byte_ready_o <= 1'b1;
      bus.en_w_rom_o   <= 1'b0;
      bus.cpu_hold_o   <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.w_rom_addr_o <= '0;
      bus.w_rom_data_o <= '0;
      n_words          <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      len_l            <= '0;
      csum             <= '0;
      word_lo          <= '0;
      to_cnt           <= '0;
    end else begin
      bus.en_w_rom_o <= 1'b0;
      bus.done_o     <= 1'b0;

      if (xfer)          to_cnt <= '0;
      else if (counting) to_cnt <= to_cnt + TO_W'(1);

      case (state)
        S_IDLE: begin
          if (xfer && (bus.byte_i == SYNC)) begin
            state          <= S_LEN;
            bus.cpu_hold_o <= 1'b1;
            bus.err_o      <= 1'b0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            csum           <= '0;
          end
        end

        S_LEN: begin
          if (xfer) begin
            if (byte_cnt == 2'd0) begin
              len_l    <= bus.byte_i;
              byte_cnt <= 2'd1;
            end else begin
              byte_cnt <= 2'd0;
              n_words  <= n_new;
              if ((n_new == 16'd0) || ({1'b0, n_new} > N_MAX)) begin
                state            <= S_ERR;
                bus.byte_ready_o <= 1'b0;
                bus.err_o        <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (to_hit) begin
            state            <= S_ERR;
            bus.byte_ready_o <= 1'b0;
            bus.err_o        <= 1'b1;
          end
        end

        S_DATA: begin
          if (xfer) begin
            csum     <= csum ^ bus.byte_i;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_lo[7:0]   <= bus.byte_i;
              2'd1: word_lo[15:8]  <= bus.byte_i;
              2'd2: word_lo[23:16] <= bus.byte_i;
              default: begin
                state            <= S_WRITE;
                bus.byte_ready_o <= 1'b0;
                bus.en_w_rom_o   <= 1'b1;
                bus.w_rom_addr_o <= word_idx;
                bus.w_rom_data_o <= {bus.byte_i, word_lo};
              end
            endcase
          end else if (to_hit) begin
            state            <= S_ERR;
            bus.byte_ready_o <= 1'b0;
            bus.err_o        <= 1'b1;
          end
        end

        S_WRITE: begin
          word_idx         <= idx_next[15:0];
          bus.byte_ready_o <= 1'b1;
          state            <= (idx_next < {1'b0, n_words}) ? S_DATA : S_CSUM;
        end

        S_CSUM: begin
          if (xfer) begin
            bus.byte_ready_o <= 1'b0;
            if (bus.byte_i == csum) begin
              state      <= S_DONE;
              bus.done_o <= 1'b1;
            end else begin
              state     <= S_ERR;
              bus.err_o <= 1'b1;
            end
          end else if (to_hit) begin
            state            <= S_ERR;
            bus.byte_ready_o <= 1'b0;
            bus.err_o        <= 1'b1;
          end
        end

        default: begin
          state            <= S_IDLE;
          bus.byte_ready_o <= 1'b1;
          bus.cpu_hold_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter MAX_ROM_ADDR, default 255: highest writable ROM word address.
REQ-002 Parameter TIMEOUT, default 1000: maximum idle cycles allowed between bytes inside a frame.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 byte_i  input  8  incoming load-stream byte.
REQ-006 byte_valid_i  input  1  byte_i is valid this cycle.
REQ-007 byte_ready_o  output  1  loader accepts byte_i this cycle; a byte transfers when byte_valid_i and byte_ready_o are both 1.
REQ-008 w_rom_addr_o  output  16  ROM write word address.
REQ-009 w_rom_data_o  output  32  ROM write data.
REQ-010 en_w_rom_o  output  1  ROM write enable, active-high, one-cycle pulse per word.
REQ-011 cpu_hold_o  output  1  holds the core (PC frozen) while a frame is in progress.
REQ-012 done_o  output  1  one-cycle pulse on successful frame completion.
REQ-013 err_o  output  1  sticky error flag.

Function
REQ-014 Frame format: sync 0xA5; LEN_L; LEN_H (N = word count); N words of 4 bytes each, least-significant byte first; CSUM = XOR of all 4N data bytes.
REQ-015 FSM states: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
REQ-016 IDLE: a byte equal to 0xA5 moves the FSM to LEN, clears err_o, the word index, the checksum accumulator and the timeout counter; any other byte is discarded.
REQ-017 LEN: accepts 2 bytes. After LEN_H, if N==0 or N>MAX_ROM_ADDR+1 the FSM goes to ERR; otherwise it goes to DATA.
REQ-018 DATA: each accepted byte is shifted into the word register at lane (byte count mod 4) and XORed into the accumulator; the 4th byte moves the FSM to WRITE.
REQ-019 WRITE: lasts exactly 1 cycle; en_w_rom_o=1, w_rom_addr_o = word index, w_rom_data_o = the assembled word.
REQ-020 After WRITE, the word index increments; the FSM returns to DATA if index<N, otherwise it goes to CSUM.
REQ-021 CSUM: the accepted byte is compared with the accumulator; a match goes to DONE, a mismatch goes to ERR.
REQ-022 DONE: lasts 1 cycle, done_o=1, then the FSM returns to IDLE.
REQ-023 ERR: lasts 1 cycle, sets err_o, then the FSM returns to IDLE; words already written stay in ROM.
REQ-024 byte_ready_o=1 in IDLE, LEN, DATA and CSUM; byte_ready_o=0 in WRITE, DONE and ERR; bytes offered while ready=0 are not consumed.
REQ-025 cpu_hold_o=1 in every state except IDLE, including the DONE and ERR cycles; it drops the cycle after DONE or ERR.
REQ-026 Timeout counter: reset by each accepted byte, incremented every cycle spent in LEN, DATA or CSUM without a transfer; reaching TIMEOUT sends the FSM to ERR.
REQ-027 A 0xA5 byte arriving inside a frame is treated as ordinary data; there is no resync mid-frame.
REQ-028 Word index is 16 bits; no wrap can occur because N is bounded by REQ-017.
REQ-029 Outside WRITE, en_w_rom_o=0; w_rom_addr_o and w_rom_data_o hold their last values.

Reset
REQ-030 rst_i=0 immediately forces state IDLE and sets byte_ready_o=1, en_w_rom_o=0, cpu_hold_o=0, done_o=0, err_o=0, w_rom_addr_o=0, w_rom_data_o=0, and clears all counters and the accumulator.
REQ-031 Reset asserted mid-frame aborts the frame with no further ROM writes; the loader restarts in IDLE waiting for a sync byte.

Verification
REQ-032 Frame A5 02 00 | 11 22 33 44 | 55 66 77 88 | CSUM 0x88 -> two write pulses: addr 0 data 0x44332211, then addr 1 data 0x88776655; done_o pulses once; err_o=0.
REQ-033 Same frame with CSUM 0x00 -> both words written, err_o=1, no done_o pulse, cpu_hold_o drops one cycle after ERR.
REQ-034 LEN = 0x0000, then LEN = MAX_ROM_ADDR+2 -> ERR directly after LEN_H in both cases, no write pulses.
REQ-035 Stream stalls for TIMEOUT cycles after the 2nd data byte -> ERR, err_o=1, no write for the partial word.
REQ-036 Bytes 0x00, 0x13 followed by a valid frame in IDLE -> the first two bytes are ignored and the frame loads normally; byte_valid_i held high throughout -> byte_ready_o=0 for exactly one cycle per word.
REQ-037 rst_i pulsed low in DATA after 1 word -> outputs at reset values asynchronously; a following full frame loads correctly.
